// File: rtl/logic_unit_pkg.sv
// Shared op-code encoding for the pipelined bitwise logic unit.
package logic_unit_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND   = 3'b000;
  localparam logic [OP_W-1:0] OP_OR    = 3'b001;
  localparam logic [OP_W-1:0] OP_XOR   = 3'b010;
  localparam logic [OP_W-1:0] OP_NAND  = 3'b011;
  localparam logic [OP_W-1:0] OP_NOR   = 3'b100;
  localparam logic [OP_W-1:0] OP_XNOR  = 3'b101;
  localparam logic [OP_W-1:0] OP_NOTA  = 3'b110;
  localparam logic [OP_W-1:0] OP_PASSB = 3'b111;

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bundle between operand fetch, the logic unit and the result mux.
interface logic_unit_pipe_if #(
  parameter int unsigned WIDTH = 32
);
  import logic_unit_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [OP_W-1:0]  op;
  logic             acc_sel;
  logic             acc_wr;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out1;
  logic             zero;
  logic             ones;
  logic             parity;

  modport master (
    output in_valid, in1, in2, op, acc_sel, acc_wr, acc_clr, out_ready,
    input  in_ready, out_valid, out1, zero, ones, parity
  );

  modport slave (
    input  in_valid, in1, in2, op, acc_sel, acc_wr, acc_clr, out_ready,
    output in_ready, out_valid, out1, zero, ones, parity
  );

endinterface

// File: rtl/logic_op_comb.sv
// Combinational WIDTH-bit bitwise operation datapath.
module logic_op_comb
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      OP_NAND:  y = ~(a & b);
      OP_NOR:   y = ~(a | b);
      OP_XNOR:  y = ~(a ^ b);
      OP_NOTA:  y = ~a;
      OP_PASSB: y = b;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined logic unit with valid/ready handshake, accumulator operand and result flags.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  logic_unit_pipe_if.slave   bus
);

  logic             rdy_q;
  logic             v1_q;
  logic [WIDTH-1:0] r1_q;
  logic             ov_q;
  logic [WIDTH-1:0] out_q;
  logic             zero_q;
  logic             ones_q;
  logic             par_q;
  logic [WIDTH-1:0] acc_q;

  logic             s1_adv;
  logic             s2_adv;
  logic             ready_c;
  logic             accept;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] res;

  // Backpressure ripples straight from out_ready; no skid buffer.
  assign s2_adv  = !ov_q || bus.out_ready;
  assign s1_adv  = !v1_q || s2_adv;
  assign ready_c = rdy_q && s1_adv;
  assign accept  = bus.in_valid && ready_c;
  assign opa     = bus.acc_sel ? acc_q : bus.in1;

  logic_op_comb #(.WIDTH(WIDTH)) u_op (
    .a  (opa),
    .b  (bus.in2),
    .op (bus.op),
    .y  (res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q  <= 1'b0;
      v1_q   <= 1'b0;
      r1_q   <= '0;
      ov_q   <= 1'b0;
      out_q  <= '0;
      zero_q <= 1'b0;
      ones_q <= 1'b0;
      par_q  <= 1'b0;
      acc_q  <= '0;
    end else begin
      rdy_q <= 1'b1;

      if (s1_adv) begin
        v1_q <= accept;
        if (accept) r1_q <= res;
      end

      // Flags are derived from the stage-1 value so they always match out1.
      if (s2_adv) begin
        ov_q <= v1_q;
        if (v1_q) begin
          out_q  <= r1_q;
          zero_q <= (r1_q == '0);
          ones_q <= (r1_q == {WIDTH{1'b1}});
          par_q  <= ^r1_q;
        end
      end

      // Clear beats a simultaneous accepted write.
      if (bus.acc_clr)            acc_q <= '0;
      else if (accept && bus.acc_wr) acc_q <= res;
    end
  end

  assign bus.in_ready  = ready_c;
  assign bus.out_valid = ov_q;
  assign bus.out1      = out_q;
  assign bus.zero      = zero_q;
  assign bus.ones      = ones_q;
  assign bus.parity    = par_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: table vectors, stall/reset sequences and random traffic.
module tb_logic_unit_pipe;

  localparam int unsigned W = 8;

  logic clk;
  logic rst_n;

  logic_unit_pipe_if #(.WIDTH(W)) bus ();

  logic_unit_pipe #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         vld;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sel;
    logic         wr;
    logic         clr;
    logic [W-1:0] exp;
  } vec_t;

  typedef struct {
    logic [W-1:0] val;
    int           t;
    logic         has_tab;
    logic [W-1:0] tab;
  } sb_t;

  int           checks = 0;
  int           errors = 0;
  int           ticks = 0;
  int           acc_cnt = 0;
  logic         got_acc;
  logic         chk_rdy = 1'b0;
  logic         lat_exact = 1'b0;
  logic         tab_on = 1'b0;
  logic [W-1:0] tab_exp = '0;
  logic [W-1:0] macc = '0;
  sb_t          sq[$];
  vec_t         tab[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return ~(a ^ b);
      3'd6:    return ~a;
      default: return b;
    endcase
  endfunction

  // {zero, ones, parity} from counting set bits.
  function automatic logic [2:0] flags_of(input logic [W-1:0] v);
    int n = 0;
    for (int i = 0; i < int'(W); i++) if (v[i]) n++;
    return {n == 0, n == int'(W), (n % 2) == 1};
  endfunction

  function automatic vec_t mk(input logic vld, input logic [2:0] op, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic sel, input logic wr,
                              input logic clr, input logic [W-1:0] exp);
    vec_t v;
    v.vld = vld; v.op = op; v.a = a; v.b = b;
    v.sel = sel; v.wr = wr; v.clr = clr; v.exp = exp;
    return v;
  endfunction

  // Scoreboard step, evaluated on the falling edge when inputs and outputs are settled.
  task automatic sample();
    sb_t      e;
    logic [2:0] f;
    ticks++;
    got_acc = 1'b0;
    if (chk_rdy)
      chk("in_ready", 32'(bus.in_ready), 32'(!(sq.size() == 2 && !bus.out_ready)));
    if (bus.out_valid) begin
      if (sq.size() == 0) begin
        chk("spurious_out_valid", 32'(bus.out_valid), 32'd0);
      end else begin
        e = sq[0];
        f = flags_of(e.val);
        chk("out1", 32'(bus.out1), 32'(e.val));
        chk("flags", 32'({bus.zero, bus.ones, bus.parity}), 32'(f));
        if (bus.out_ready) begin
          void'(sq.pop_front());
          if (e.has_tab) chk("table_out1", 32'(bus.out1), 32'(e.tab));
          if (lat_exact) chk("latency", 32'(ticks - e.t), 32'd2);
          else if (ticks - e.t < 2) chk("latency_min", 32'(ticks - e.t), 32'd2);
        end
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      got_acc = 1'b1;
      acc_cnt++;
      e.val = model(bus.op, bus.acc_sel ? macc : bus.in1, bus.in2);
      e.t = ticks;
      e.has_tab = tab_on;
      e.tab = tab_exp;
      sq.push_back(e);
      if (bus.acc_clr) macc = '0;
      else if (bus.acc_wr) macc = e.val;
    end else if (bus.acc_clr) begin
      macc = '0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_row(input vec_t r, input int idx);
    bus.in_valid = r.vld;
    bus.op = r.op;
    bus.in1 = r.a;
    bus.in2 = r.b;
    bus.acc_sel = r.sel;
    bus.acc_wr = r.wr;
    bus.acc_clr = r.clr;
    tab_on = r.vld;
    tab_exp = r.exp;
    tick();
    if (r.vld) chk($sformatf("accept_row%0d", idx), 32'(got_acc), 32'd1);
    tab_on = 1'b0;
    bus.in_valid = 1'b0;
    bus.acc_clr = 1'b0;
    bus.acc_wr = 1'b0;
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    bus.acc_clr = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10 && sq.size() != 0; i++) tick();
    tick();
    chk("drain_empty", 32'(sq.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    bus.in_valid = 1'b0; bus.in1 = '0; bus.in2 = '0; bus.op = '0;
    bus.acc_sel = 1'b0; bus.acc_wr = 1'b0; bus.acc_clr = 1'b0; bus.out_ready = 1'b1;
    rst_n = 1'b0;

    // Operand sweep, flag corners, accumulator chain, clear/write collision.
    tab.push_back(mk(1, 3'd0, 8'hF0, 8'h3C, 0, 0, 0, 8'h30));
    tab.push_back(mk(1, 3'd1, 8'hF0, 8'h3C, 0, 0, 0, 8'hFC));
    tab.push_back(mk(1, 3'd2, 8'hF0, 8'h3C, 0, 0, 0, 8'hCC));
    tab.push_back(mk(1, 3'd3, 8'hF0, 8'h3C, 0, 0, 0, 8'hCF));
    tab.push_back(mk(1, 3'd4, 8'hF0, 8'h3C, 0, 0, 0, 8'h03));
    tab.push_back(mk(1, 3'd5, 8'hF0, 8'h3C, 0, 0, 0, 8'h33));
    tab.push_back(mk(1, 3'd6, 8'hF0, 8'h3C, 0, 0, 0, 8'h0F));
    tab.push_back(mk(1, 3'd7, 8'hF0, 8'h3C, 0, 0, 0, 8'h3C));
    tab.push_back(mk(1, 3'd0, 8'hAA, 8'h55, 0, 0, 0, 8'h00));
    tab.push_back(mk(1, 3'd5, 8'h0F, 8'h0F, 0, 0, 0, 8'hFF));
    tab.push_back(mk(1, 3'd1, 8'h01, 8'h00, 0, 0, 0, 8'h01));
    tab.push_back(mk(0, 3'd0, 8'h00, 8'h00, 0, 0, 1, 8'h00));
    tab.push_back(mk(1, 3'd1, 8'h01, 8'h00, 0, 1, 0, 8'h01));
    tab.push_back(mk(1, 3'd1, 8'hEE, 8'h02, 1, 1, 0, 8'h03));
    tab.push_back(mk(1, 3'd2, 8'hEE, 8'hFF, 1, 0, 0, 8'hFC));
    tab.push_back(mk(1, 3'd7, 8'h00, 8'h55, 0, 1, 0, 8'h55));
    tab.push_back(mk(1, 3'd0, 8'h12, 8'hFF, 1, 1, 1, 8'h55));
    tab.push_back(mk(1, 3'd1, 8'h34, 8'h00, 1, 0, 0, 8'h00));

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out1", 32'(bus.out1), 32'd0);
    chk("rst_flags", 32'({bus.zero, bus.ones, bus.parity}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", 32'(bus.in_ready), 32'd1);
    chk_rdy = 1'b1;

    lat_exact = 1'b1;
    for (int i = 0; i < tab.size(); i++) apply_row(tab[i], i);
    drain();
    lat_exact = 1'b0;

    // Four cycles of backpressure with continuous offers.
    a0 = acc_cnt;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.op = 3'($urandom_range(0, 7));
      bus.in1 = W'($urandom);
      bus.in2 = W'($urandom);
      bus.acc_sel = 1'b0;
      tick();
    end
    chk("stall_accepts", 32'(acc_cnt - a0), 32'd2);
    chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    drain();

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      bus.in_valid = ($urandom_range(0, 9) < 7);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.op = 3'($urandom_range(0, 7));
      bus.in1 = W'($urandom);
      bus.in2 = W'($urandom);
      bus.acc_sel = 1'($urandom_range(0, 1));
      bus.acc_wr = 1'($urandom_range(0, 1));
      bus.acc_clr = ($urandom_range(0, 9) == 0);
      tick();
    end
    bus.acc_wr = 1'b0;
    drain();

    // Reset with both stages full and a non-zero accumulator.
    bus.out_ready = 1'b0;
    apply_row(mk(1, 3'd7, 8'h00, 8'hA5, 0, 1, 0, 8'hA5), 100);
    apply_row(mk(1, 3'd1, 8'h80, 8'h00, 0, 0, 0, 8'h80), 101);
    chk("pre_reset_out_valid", 32'(bus.out_valid), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(bus.out_valid), 32'd0);
    chk("async_out1", 32'(bus.out1), 32'd0);
    chk("async_flags", 32'({bus.zero, bus.ones, bus.parity}), 32'd0);
    sq.delete();
    macc = '0;
    chk_rdy = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_mid_reset", 32'(bus.in_ready), 32'd1);
    chk_rdy = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    lat_exact = 1'b1;
    apply_row(mk(1, 3'd1, 8'h77, 8'h00, 1, 0, 0, 8'h00), 102);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
Parametrised, pipelined bitwise logic unit for the ALU datapath. It is the multi-op successor to the fixed N-bit NAND array and supports AND/OR/XOR/NAND/NOR/XNOR/NOT/PASS. It adds valid/ready handshaking on both sides, an internal accumulator usable as operand A, and registered result flags (zero, all-ones, parity). It sits between the operand-fetch stage and the ALU result mux.

Parameters:
WIDTH, 32, operand/result width in bits (>=2)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream has a transaction
in_ready  output  1  unit can accept this cycle
in1  input  WIDTH  operand A (ignored when acc_sel=1)
in2  input  WIDTH  operand B
op  input  3  operation code
acc_sel  input  1  use accumulator as operand A
acc_wr  input  1  write this transaction's result into accumulator
acc_clr  input  1  synchronous accumulator clear, independent of handshake
out_valid  output  1  result available
out_ready  input  1  downstream accepts result
out1  output  WIDTH  result
zero  output  1  out1 == 0
ones  output  1  out1 == all ones
parity  output  1  XOR-reduce of out1

Behaviour:
- Clock and reset: one clock (clk); reset asynchronous, active-low (rst_n).
- Reset values: out_valid=0, out1=0, zero=0, ones=0, parity=0, accumulator=0, stage-1 valid=0. in_ready=1 one cycle after rst_n deasserts.
- Op codes: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 NOT A (in2 ignored), 111 PASS B.
- Operand A = acc_sel ? accumulator : in1.
- Accept: a transfer occurs when in_valid & in_ready at a rising edge.
- Stage 1 registers the computed result and v1 at accept.
- Stage 2 registers out1, flags and out_valid.
- Latency: out_valid rises 2 edges after the accepting edge. Throughput is 1 per cycle with no stalls.
- Advance rule: s2_adv = !out_valid | out_ready; s1_adv = !v1 | s2_adv; in_ready = s1_adv. in_ready is combinational from out_ready; no skid buffer.
- Stall: with out_valid=1 and out_ready=0, out1 and flags hold stable and stage 1 holds. in_ready drops only when v1=1 and stage 2 is stalled.
- Drain: when stage 1 moves to stage 2 with no new accept, v1 clears.
- Accumulator:
  - Written with the result at the accepting edge when acc_wr=1, so a back-to-back transaction with acc_sel=1 sees the prior result without bubbles.
  - acc_clr=1 clears it at the next edge.
  - If acc_clr and an accepted acc_wr coincide, clear wins. The transaction still reads the pre-clear value as operand.
  - acc_wr is ignored on cycles without accept.
- Flags are computed from the stage-1 result and registered together with out1, so they are always coherent with out1.
- Reset mid-operation: all in-flight transactions are discarded and the accumulator clears. There is no partial output.
- Inputs are sampled only on accept; changes while in_ready=0 have no effect.

Decomposition:
- Package logic_unit_pkg: op code localparams (OP_AND…OP_PASSB) and op width constant (3).
- Sub-module logic_op_comb: purely combinational WIDTH-bit op decoder/datapath (a, b, op -> y). It is instantiated once in stage 1.
- The pipeline, handshake, accumulator and flags live in logic_unit_pipe.

Test Plan:
1. WIDTH=8, out_ready=1; stream in1=0xF0, in2=0x3C through ops 000..111 on consecutive cycles -> out1 = 0x30,0xFC,0xCC,0xCF,0x03,0x33,0x0F,0x3C. Each appears exactly 2 cycles after accept, one per cycle.
2. Flags: AND 0xAA,0x55 -> out1=0x00, zero=1, ones=0, parity=0. XNOR 0x0F,0x0F -> 0xFF, ones=1, zero=0, parity=0. OR 0x01,0x00 -> parity=1.
3. Backpressure: out_ready=0 for 4 cycles with continuous in_valid -> exactly 2 transactions accepted, then in_ready=0. out1 stays stable. Releasing out_ready delivers all results in order with no loss or duplication.
4. Accumulator chain: acc_clr, then OR in1=0x01 acc_wr=1, then back-to-back OR acc_sel=1 in2=0x02 acc_wr=1, then XOR acc_sel=1 in2=0xFF -> outputs 0x01, 0x03, 0xFC.
5. Clear/write collision: acc=0x55; same cycle acc_clr=1 with accepted AND acc_sel=1, in2=0xFF, acc_wr=1 -> out1=0x55, accumulator=0x00 afterwards.
6. Async reset mid-stream with both stages valid: assert rst_n low between edges -> out_valid, out1, flags and accumulator go to 0 immediately. No stale result appears after rst_n rises.
